dma_controller: RTL
===================

Name: dma_controller

Overview:
- Bus-master DMA engine that moves a fixed 12-word block from an external device into data memory at a CPU-supplied base address.
- Sits directly upstream of the pipeline hazard/stall controller and produces the BR, dma_counter and dma_end signals that controller consumes.
- Bus ownership is BR/BG arbitrated; the controller freezes the pipeline while BR is high and dma_counter != 11.
- On completion it releases the bus, pulses dma_end and raises a one-cycle interrupt to the CPU.

Parameters:
WORD_SIZE, 16, data/address width
LENGTH, 12, words per transfer; the controller-side completion value is LENGTH-1 = 11
CNT_W, 4, width of dma_counter

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous reset, active-low
cmd_valid  in  1  CPU requests a transfer
cmd_addr  in  WORD_SIZE  destination base address
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
BG  in  1  bus grant from CPU
BR  out  1  bus request to CPU/hazard controller
dev_valid  in  1  device word available
dev_data  in  WORD_SIZE  device word
dev_ready  out  1  device word consumed when dev_valid & dev_ready
dma_addr  out  WORD_SIZE  memory write address
dma_data  out  WORD_SIZE  memory write data
dma_write  out  1  memory write request
mem_ack  in  1  memory accepted the current write
dma_counter  out  CNT_W  index of word in flight, 0..11
dma_end  out  1  one-cycle completion pulse
irq  out  1  one-cycle interrupt to CPU, coincident with dma_end

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: state IDLE; BR, dma_write, dma_end, irq, dev_ready all 0; dma_counter 0; dma_addr, dma_data, base register 0; hold register empty.
- States: IDLE, REQ, XFER, DONE.

IDLE:
- cmd_ready=1.
- On cmd_valid: latch cmd_addr into base, counter=0, go to REQ.

REQ:
- BR=1.
- Go to XFER on the first cycle BG=1 is sampled. No timeout.

XFER:
- BR=1.
- One-word hold register. dev_ready = hold empty & BG.
- When hold is full and BG=1:
  - dma_write=1
  - dma_addr = base + dma_counter, modulo 2^WORD_SIZE (wraps from 0xFFFF to 0x0000)
  - dma_data = hold
- dma_addr, dma_data and dma_write stay stable until mem_ack.
- mem_ack in the same cycle dma_write first rises is legal (zero wait).
- On mem_ack: hold is emptied.
  - If dma_counter == LENGTH-1, go to DONE.
  - Otherwise dma_counter += 1.
- A new device word may be captured in the same cycle the hold empties: that is, dev_ready is computed from the post-ack state, giving 1 word per cycle throughput.
- If BG drops mid-transfer:
  - dma_write=0 and dev_ready=0.
  - Counter and hold are frozen; BR stays 1.
  - Resume when BG returns.
  - A write whose mem_ack has not yet arrived is reissued.
- mem_ack while dma_write=0 is ignored.

DONE (exactly one cycle):
- BR=0, dma_end=1, irq=1, dma_counter holds 11.
- Next cycle: IDLE, dma_counter=0.

Other rules:
- cmd_valid while not in IDLE: cmd_ready=0 and the command is ignored (base case).
- Reset asserted mid-transfer: next edge returns to IDLE. The hold word is discarded, BR drops that cycle, and there is no dma_end.
- dma_counter never exceeds 11 and is never 11 except during the final word and DONE.

Optional Feature:
- Macro: DMA_CMD_QUEUE_EN.
- Defined:
  - Adds a one-entry pending command register. cmd_ready = pending empty, in any state.
  - A command accepted while busy is stored.
  - From DONE with pending valid: go to REQ (not IDLE), load base from pending, counter=0, clear pending.
  - BR is still 0 for the DONE cycle, so the CPU always sees one bus-free cycle.
  - Reset clears pending.
- Undefined: behaviour exactly as in the base case; cmd_ready=1 only in IDLE.

Test Plan:
- Reset, cmd_valid with cmd_addr=0x0100, BG tied 1 after 2 cycles, dev_valid always 1 with data 0xA000+i, mem_ack=dma_write -> 12 writes to 0x0100..0x010B with data 0xA000..0xA00B; BR high from REQ through the last ack; dma_end/irq pulse once; dma_counter reads 11 in DONE, then 0.
- cmd_addr=0xFFFA -> addresses 0xFFFA..0xFFFF then 0x0000..0x0005.
- BG dropped for 3 cycles after word 4 is acked -> no dma_write and no dev_ready during the gap, counter stays 5, BR stays 1, transfer completes with all 12 words in order.
- mem_ack delayed 2 cycles per word, dev_valid toggling every other cycle -> dma_addr/dma_data stable while awaiting ack, no word lost or duplicated.
- reset_n low during word 7 -> next cycle IDLE, BR=0, counter 0, no dma_end; a following command transfers all 12 words cleanly.
- With DMA_CMD_QUEUE_EN defined: second command 0x0200 issued during the first transfer -> accepted; after the DONE pulse, BR is 0 for one cycle, then 12 words go to 0x0200; a third command is refused (cmd_ready=0) while pending is full.

Source files
------------

// File: rtl/dma_controller.sv
// Bus-master DMA: moves a LENGTH-word block from a device into memory at a CPU-supplied base.
// Optional one-entry pending command register when DMA_CMD_QUEUE_EN is defined.
module dma_controller #(
  parameter int WORD_SIZE = 16,
  parameter int LENGTH    = 12,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  output logic                 cmd_ready,
  input  logic                 BG,
  output logic                 BR,
  input  logic                 dev_valid,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 dev_ready,
  output logic [WORD_SIZE-1:0] dma_addr,
  output logic [WORD_SIZE-1:0] dma_data,
  output logic                 dma_write,
  input  logic                 mem_ack,
  output logic [CNT_W-1:0]     dma_counter,
  output logic                 dma_end,
  output logic                 irq
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  state_t               state;
  logic [WORD_SIZE-1:0] base, hold_data;
  logic                 hold_full;
  logic                 ack_fire, last_word, capture, cmd_fire;

  // Write and device handshakes follow BG directly so a lost grant stops traffic in the same cycle.
  assign dma_write = (state == XFER) & hold_full & BG;
  assign ack_fire  = dma_write & mem_ack;
  assign last_word = (dma_counter == LAST);
  assign dev_ready = (state == XFER) & BG & (~hold_full | (ack_fire & ~last_word));
  assign capture   = dev_valid & dev_ready;
  assign dma_addr  = base + WORD_SIZE'(dma_counter);
  assign dma_data  = hold_data;
  assign cmd_fire  = cmd_valid & cmd_ready;

`ifdef DMA_CMD_QUEUE_EN
  logic                 pend_valid;
  logic [WORD_SIZE-1:0] pend_addr;
  assign cmd_ready = ~pend_valid;
`else
  assign cmd_ready = (state == IDLE);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      base        <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      dma_counter <= '0;
      BR          <= 1'b0;
      dma_end     <= 1'b0;
      irq         <= 1'b0;
`ifdef DMA_CMD_QUEUE_EN
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
`endif
    end else begin
      dma_end <= 1'b0;
      irq     <= 1'b0;
`ifdef DMA_CMD_QUEUE_EN
      if (cmd_fire && (state == REQ || state == XFER)) begin
        pend_valid <= 1'b1;
        pend_addr  <= cmd_addr;
      end
`endif
      case (state)
        IDLE: if (cmd_fire) begin
          base        <= cmd_addr;
          dma_counter <= '0;
          BR          <= 1'b1;
          state       <= REQ;
        end
        REQ: if (BG) state <= XFER;
        XFER: begin
          if (capture) begin
            hold_data <= dev_data;
            hold_full <= 1'b1;
          end else if (ack_fire) begin
            hold_full <= 1'b0;
          end
          if (ack_fire) begin
            if (last_word) begin
              state   <= DONE;
              BR      <= 1'b0;
              dma_end <= 1'b1;
              irq     <= 1'b1;
            end else begin
              dma_counter <= dma_counter + 1'b1;
            end
          end
        end
        DONE: begin
          dma_counter <= '0;
          state       <= IDLE;
`ifdef DMA_CMD_QUEUE_EN
          // Chain straight into the queued command; BR was already low for this DONE cycle.
          if (pend_valid) begin
            base       <= pend_addr;
            pend_valid <= 1'b0;
            BR         <= 1'b1;
            state      <= REQ;
          end else if (cmd_fire) begin
            base  <= cmd_addr;
            BR    <= 1'b1;
            state <= REQ;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
